tis_node_core: RTL and testbench

- Parametrised successor to the single-node program executor.
- Adds an internal writable program store, configurable depth and data width, and four blocking valid/ready neighbour ports (UP/DOWN/LEFT/RIGHT) so MOV executes.
- Also adds an explicit halt state.
- Nodes are tiled into a grid; each node's out ports connect to neighbours' in ports.

---
 rtl/tis_pkg.sv | 76 +++++++
 rtl/tis_sat_alu.sv | 44 ++++
 rtl/tis_node_core.sv | 215 +++++++++++++++++++++
 tb/tb_tis_node_core.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tis_pkg.sv
`default_nettype none
// tis_pkg -- instruction encoding, FSM states and port indices for the TIS node core.
// Rev 1.0
package tis_pkg;

  localparam int INSTR_W    = 24;
  localparam int IMM_W      = 11;
  localparam int NUM_PORTS  = 4;
  localparam int PORT_UP    = 0;
  localparam int PORT_DOWN  = 1;
  localparam int PORT_LEFT  = 2;
  localparam int PORT_RIGHT = 3;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_MOV  = 4'h1,
    OP_ADD  = 4'h2,
    OP_SUB  = 4'h3,
    OP_JRO  = 4'h4,
    OP_JMP  = 4'h5,
    OP_JEZ  = 4'h6,
    OP_JNZ  = 4'h7,
    OP_JGZ  = 4'h8,
    OP_JLZ  = 4'h9,
    OP_SWP  = 4'hA,
    OP_SAV  = 4'hB,
    OP_NEG  = 4'hC,
    OP_HCF  = 4'hD,
    OP_RSVE = 4'hE,
    OP_RSVF = 4'hF
  } op_e;

  typedef enum logic [2:0] {
    SRC_IMM   = 3'd0,
    SRC_ACC   = 3'd1,
    SRC_NIL   = 3'd2,
    SRC_UP    = 3'd3,
    SRC_DOWN  = 3'd4,
    SRC_LEFT  = 3'd5,
    SRC_RIGHT = 3'd6,
    SRC_NIL7  = 3'd7
  } src_e;

  typedef enum logic [2:0] {
    DST_RSV0  = 3'd0,
    DST_ACC   = 3'd1,
    DST_NIL   = 3'd2,
    DST_UP    = 3'd3,
    DST_DOWN  = 3'd4,
    DST_LEFT  = 3'd5,
    DST_RIGHT = 3'd6,
    DST_RSV7  = 3'd7
  } dst_e;

  typedef struct packed {
    op_e              op;
    src_e             src;
    dst_e             dst;
    logic [2:0]       rsvd;
    logic [IMM_W-1:0] imm;
  } instr_t;

  typedef enum logic [1:0] {
    ALU_ADD = 2'd0,
    ALU_SUB = 2'd1,
    ALU_NEG = 2'd2
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_WR_WAIT = 2'd1,
    ST_HALT    = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/tis_sat_alu.sv
`default_nettype none
// tis_sat_alu -- combinational add/sub/neg computed one bit wider, clamped to +/-SAT_MAX.
// Rev 1.0
module tis_sat_alu
  import tis_pkg::*;
#(
  parameter int DATA_W  = 11,
  parameter int SAT_MAX = 999
) (
  input  alu_op_e                  op_i,
  input  logic signed [DATA_W-1:0] a_i,
  input  logic signed [DATA_W-1:0] b_i,
  output logic signed [DATA_W-1:0] res_o
);

  localparam int EW = DATA_W + 1;
  localparam logic signed [EW-1:0] MAX_V = EW'(SAT_MAX);
  localparam logic signed [EW-1:0] MIN_V = -MAX_V;

  logic signed [EW-1:0] w_a_ext;
  logic signed [EW-1:0] w_b_ext;
  logic signed [EW-1:0] w_sum;

  always_comb begin
    w_a_ext = EW'(a_i);
    w_b_ext = EW'(b_i);
    w_sum   = w_a_ext;
    case (op_i)
      ALU_ADD: w_sum = w_a_ext + w_b_ext;
      ALU_SUB: w_sum = w_a_ext - w_b_ext;
      ALU_NEG: w_sum = -w_a_ext;
      default: w_sum = w_a_ext;
    endcase
    if (w_sum > MAX_V) begin
      res_o = MAX_V[DATA_W-1:0];
    end else if (w_sum < MIN_V) begin
      res_o = MIN_V[DATA_W-1:0];
    end else begin
      res_o = w_sum[DATA_W-1:0];
    end
  end

endmodule
`default_nettype wire

// File: rtl/tis_node_core.sv
`default_nettype none
// tis_node_core -- TIS-style node: writable program store, blocking neighbour ports, halt state.
// Rev 1.0
module tis_node_core
  import tis_pkg::*;
#(
  parameter int PROG_DEPTH = 15,
  parameter int DATA_W     = 11,
  parameter int SAT_MAX    = 999,
  parameter int PC_W       = $clog2(PROG_DEPTH)
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  run,
  input  logic [PC_W-1:0]                       prog_len,
  input  logic                                  prog_we,
  input  logic [PC_W-1:0]                       prog_addr,
  input  logic [INSTR_W-1:0]                    prog_wdata,
  input  logic [NUM_PORTS-1:0][DATA_W-1:0]      in_data,
  input  logic [NUM_PORTS-1:0]                  in_valid,
  output logic [NUM_PORTS-1:0]                  in_ready,
  output logic [NUM_PORTS-1:0][DATA_W-1:0]      out_data,
  output logic [NUM_PORTS-1:0]                  out_valid,
  input  logic [NUM_PORTS-1:0]                  out_ready,
  output logic [PC_W-1:0]                       pc,
  output logic signed [DATA_W-1:0]              acc,
  output logic signed [DATA_W-1:0]              bak,
  output logic                                  halted,
  output logic                                  stall
);

  localparam int JW = ((DATA_W > PC_W) ? DATA_W : PC_W) + 2;

  logic [INSTR_W-1:0] mem_q [PROG_DEPTH];

  state_e                           state_q, state_d;
  logic [PC_W-1:0]                  pc_q, pc_d;
  logic signed [DATA_W-1:0]         acc_q, acc_d;
  logic signed [DATA_W-1:0]         bak_q, bak_d;
  logic [NUM_PORTS-1:0]             out_valid_q, out_valid_d;
  logic [NUM_PORTS-1:0][DATA_W-1:0] out_data_q, out_data_d;
  logic [1:0]                       wr_port_q, wr_port_d;
  logic                             halted_q, halted_d;

  instr_t                   w_instr;
  logic                     w_issue;
  logic                     w_uses_src;
  logic                     w_src_is_port;
  logic [1:0]               w_src_port;
  logic [1:0]               w_dst_port;
  logic                     w_operand_ok;
  logic signed [DATA_W-1:0] w_imm_ext;
  logic signed [DATA_W-1:0] w_operand;
  logic signed [DATA_W-1:0] w_alu_res;
  alu_op_e                  w_alu_op;
  logic [PC_W-1:0]          w_last;
  logic [PC_W-1:0]          w_seq_pc;
  logic [PC_W-1:0]          w_jmp_pc;
  logic [PC_W-1:0]          w_jro_pc;
  logic signed [JW-1:0]     w_jro_sum;
  logic signed [JW-1:0]     w_last_ext;
  logic                     w_unused;

  always_ff @(posedge clk) begin
    if (prog_we && (32'(prog_addr) < PROG_DEPTH)) begin
      mem_q[prog_addr] <= prog_wdata;
    end
  end

  // Fetch sees the stored word; a same-cycle write only lands at the edge.
  assign w_instr   = (32'(pc_q) < PROG_DEPTH) ? instr_t'(mem_q[pc_q]) : instr_t'('0);
  assign w_unused  = ^w_instr.rsvd;
  assign w_issue   = (state_q == ST_RUN) && run && (prog_len != '0);
  assign w_imm_ext = DATA_W'($signed(w_instr.imm));

  assign w_uses_src    = (w_instr.op == OP_MOV) || (w_instr.op == OP_ADD) ||
                         (w_instr.op == OP_SUB) || (w_instr.op == OP_JRO);
  assign w_src_is_port = (w_instr.src >= SRC_UP) && (w_instr.src <= SRC_RIGHT);
  assign w_src_port    = 2'(3'(w_instr.src) - 3'(SRC_UP));
  assign w_dst_port    = 2'(3'(w_instr.dst) - 3'(DST_UP));
  assign w_operand_ok  = !(w_uses_src && w_src_is_port) || in_valid[w_src_port];

  always_comb begin
    w_operand = '0;
    case (w_instr.src)
      SRC_IMM:                               w_operand = w_imm_ext;
      SRC_ACC:                               w_operand = acc_q;
      SRC_UP, SRC_DOWN, SRC_LEFT, SRC_RIGHT: w_operand = in_data[w_src_port];
      default:                               w_operand = '0;
    endcase
  end

  assign w_alu_op = (w_instr.op == OP_SUB) ? ALU_SUB :
                    (w_instr.op == OP_NEG) ? ALU_NEG : ALU_ADD;

  tis_sat_alu #(
    .DATA_W  (DATA_W),
    .SAT_MAX (SAT_MAX)
  ) u_alu (
    .op_i  (w_alu_op),
    .a_i   (acc_q),
    .b_i   (w_operand),
    .res_o (w_alu_res)
  );

  // A pc beyond a shrunken prog_len also wraps on the next advance.
  assign w_last     = prog_len - 1'b1;
  assign w_seq_pc   = (pc_q >= w_last) ? '0 : pc_q + 1'b1;
  assign w_jmp_pc   = (w_instr.imm[PC_W-1:0] >= prog_len) ? w_last : w_instr.imm[PC_W-1:0];
  assign w_jro_sum  = $signed({{(JW-PC_W){1'b0}}, pc_q}) + JW'(w_operand);
  assign w_last_ext = $signed({{(JW-PC_W){1'b0}}, w_last});
  assign w_jro_pc   = w_jro_sum[JW-1]          ? '0     :
                      (w_jro_sum > w_last_ext) ? w_last : w_jro_sum[PC_W-1:0];

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    acc_d       = acc_q;
    bak_d       = bak_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    wr_port_d   = wr_port_q;
    halted_d    = halted_q;
    in_ready    = '0;
    stall       = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (w_issue) begin
          if (w_uses_src && w_src_is_port) begin
            in_ready[w_src_port] = 1'b1;
          end
          if (!w_operand_ok) begin
            stall = 1'b1;
          end else begin
            pc_d = w_seq_pc;
            case (w_instr.op)
              OP_MOV: begin
                case (w_instr.dst)
                  DST_ACC: acc_d = w_operand;
                  DST_UP, DST_DOWN, DST_LEFT, DST_RIGHT: begin
                    out_data_d[w_dst_port]  = w_operand;
                    out_valid_d[w_dst_port] = 1'b1;
                    wr_port_d               = w_dst_port;
                    state_d                 = ST_WR_WAIT;
                    pc_d                    = pc_q;
                  end
                  default: ;
                endcase
              end
              OP_ADD, OP_SUB, OP_NEG: acc_d = w_alu_res;
              OP_JRO: pc_d = w_jro_pc;
              OP_JMP: pc_d = w_jmp_pc;
              OP_JEZ: if (acc_q == '0) pc_d = w_jmp_pc;
              OP_JNZ: if (acc_q != '0) pc_d = w_jmp_pc;
              OP_JGZ: if (!acc_q[DATA_W-1] && (acc_q != '0)) pc_d = w_jmp_pc;
              OP_JLZ: if (acc_q[DATA_W-1]) pc_d = w_jmp_pc;
              OP_SWP: begin
                acc_d = bak_q;
                bak_d = acc_q;
              end
              OP_SAV: bak_d = acc_q;
              OP_HCF: begin
                halted_d = 1'b1;
                state_d  = ST_HALT;
                pc_d     = pc_q;
              end
              default: ;
            endcase
          end
        end
      end
      ST_WR_WAIT: begin
        stall = 1'b1;
        if (out_ready[wr_port_q]) begin
          out_valid_d[wr_port_q] = 1'b0;
          pc_d                   = w_seq_pc;
          state_d                = ST_RUN;
        end
      end
      ST_HALT: ;
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_RUN;
      pc_q        <= '0;
      acc_q       <= '0;
      bak_q       <= '0;
      out_valid_q <= '0;
      out_data_q  <= '0;
      wr_port_q   <= '0;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      acc_q       <= acc_d;
      bak_q       <= bak_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      wr_port_q   <= wr_port_d;
      halted_q    <= halted_d;
    end
  end

  assign pc        = pc_q;
  assign acc       = acc_q;
  assign bak       = bak_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign halted    = halted_q;

endmodule
`default_nettype wire

// File: tb/tb_tis_node_core.sv
`default_nettype none
// tb_tis_node_core -- directed programs with a state/output scoreboard for tis_node_core.
// Rev 1.0
module tb_tis_node_core;

  localparam int DW = 11;
  localparam int PW = 4;

  logic                  clk        = 1'b0;
  logic                  rst        = 1'b1;
  logic                  run        = 1'b0;
  logic [PW-1:0]         prog_len   = '0;
  logic                  prog_we    = 1'b0;
  logic [PW-1:0]         prog_addr  = '0;
  logic [23:0]           prog_wdata = '0;
  logic [3:0][DW-1:0]    in_data    = '0;
  logic [3:0]            in_valid   = '0;
  logic [3:0]            in_ready;
  logic [3:0][DW-1:0]    out_data;
  logic [3:0]            out_valid;
  logic [3:0]            out_ready  = '0;
  logic [PW-1:0]         pc;
  logic signed [DW-1:0]  acc;
  logic signed [DW-1:0]  bak;
  logic                  halted;
  logic                  stall;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    string    name;
    int       pc;
    int       acc;
    int       bak;
    bit       halted;
    bit       stall;
    bit [3:0] in_ready;
    bit [3:0] out_valid;
    int       od3;
  } snap_t;

  typedef struct {
    int port;
    int data;
  } wr_t;

  snap_t q_snap[$];
  wr_t   q_out[$];

  tis_node_core dut (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .prog_len   (prog_len),
    .prog_we    (prog_we),
    .prog_addr  (prog_addr),
    .prog_wdata (prog_wdata),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .pc         (pc),
    .acc        (acc),
    .bak        (bak),
    .halted     (halted),
    .stall      (stall)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] ins(input int op, input int src, input int dst, input int imm);
    return {op[3:0], src[2:0], dst[2:0], 3'b000, imm[10:0]};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input logic [23:0] w);
    prog_we    = 1'b1;
    prog_addr  = a[PW-1:0];
    prog_wdata = w;
    step();
    prog_we    = 1'b0;
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic exp_st(input string nm, input int p, input int a, input int b, input bit h,
                        input bit s, input bit [3:0] ir, input bit [3:0] ov, input int od);
    snap_t e;
    e.name = nm; e.pc = p; e.acc = a; e.bak = b; e.halted = h; e.stall = s;
    e.in_ready = ir; e.out_valid = ov; e.od3 = od;
    q_snap.push_back(e);
  endtask

  // Monitor: one expected snapshot per cycle, plus every completed output handshake.
  always @(negedge clk) begin
    snap_t e;
    wr_t   w;
    logic [DW-1:0] od_act;
    if (q_snap.size() > 0) begin
      e = q_snap.pop_front();
      n_cmp++;
      od_act = out_data[3];
      if ((pc !== e.pc[PW-1:0]) || (acc !== e.acc[DW-1:0]) || (bak !== e.bak[DW-1:0]) ||
          (halted !== e.halted) || (stall !== e.stall) || (in_ready !== e.in_ready) ||
          (out_valid !== e.out_valid) || (od_act !== e.od3[DW-1:0])) begin
        n_fail++;
        $display("FAIL %s: got pc=%0d acc=%0d bak=%0d halted=%b stall=%b in_ready=%b out_valid=%b od3=%0d; want pc=%0d acc=%0d bak=%0d halted=%b stall=%b in_ready=%b out_valid=%b od3=%0d",
                 e.name, pc, acc, bak, halted, stall, in_ready, out_valid, $signed(od_act),
                 e.pc, e.acc, e.bak, e.halted, e.stall, e.in_ready, e.out_valid, e.od3);
      end
    end
    for (int p = 0; p < 4; p++) begin
      if (out_valid[p] && out_ready[p]) begin
        n_cmp++;
        if (q_out.size() == 0) begin
          n_fail++;
          $display("FAIL out_unexpected: got port=%0d data=%0d; want no write", p, $signed(out_data[p]));
        end else begin
          w = q_out.pop_front();
          od_act = out_data[p];
          if ((p != w.port) || (od_act !== w.data[DW-1:0])) begin
            n_fail++;
            $display("FAIL out_write: got port=%0d data=%0d; want port=%0d data=%0d",
                     p, $signed(od_act), w.port, w.data);
          end
        end
      end
    end
  end

  initial begin
    step();
    step();
    rst = 1'b0;
    exp_st("reset", 0, 0, 0, 0, 0, 4'b0000, 4'b0000, 0);
    step();

    // 1: saturation on repeated ADD 600 with a 2-entry program
    wr(0, ins(2, 0, 0, 600));
    wr(1, ins(2, 0, 0, 600));
    prog_len = 4'd2;
    run = 1'b1;
    exp_st("sat_c0", 0, 0,   0, 0, 0, 4'b0, 4'b0, 0); step();
    exp_st("sat_c1", 1, 600, 0, 0, 0, 4'b0, 4'b0, 0); step();
    exp_st("sat_c2", 0, 999, 0, 0, 0, 4'b0, 4'b0, 0); step();
    exp_st("sat_c3", 1, 999, 0, 0, 0, 4'b0, 4'b0, 0); step();
    exp_st("sat_c4", 0, 999, 0, 0, 0, 4'b0, 4'b0, 0);
    run = 1'b0;
    step();

    // 2: ADD 5, SAV, NEG, SWP
    pulse_rst();
    wr(0, ins(2, 0, 0, 5));
    wr(1, ins(11, 0, 0, 0));
    wr(2, ins(12, 0, 0, 0));
    wr(3, ins(10, 0, 0, 0));
    prog_len = 4'd4;
    run = 1'b1;
    exp_st("reg_c0", 0, 0,  0,  0, 0, 4'b0, 4'b0, 0); step();
    exp_st("reg_add", 1, 5, 0,  0, 0, 4'b0, 4'b0, 0); step();
    exp_st("reg_sav", 2, 5, 5,  0, 0, 4'b0, 4'b0, 0); step();
    exp_st("reg_neg", 3, -5, 5, 0, 0, 4'b0, 4'b0, 0); step();
    exp_st("reg_swp", 0, 5, -5, 0, 0, 4'b0, 4'b0, 0);
    run = 1'b0;
    step();

    // 3: JRO clamping high and low, JMP clamping
    pulse_rst();
    wr(0, ins(0, 0, 0, 0));
    wr(1, ins(4, 0, 0, 10));
    wr(2, ins(0, 0, 0, 0));
    wr(3, ins(4, 0, 0, -7));
    run = 1'b1;
    exp_st("jro_c0",  0, 0, 0, 0, 0, 4'b0, 4'b0, 0); step();
    exp_st("jro_p1",  1, 0, 0, 0, 0, 4'b0, 4'b0, 0); step();
    exp_st("jro_hi",  3, 0, 0, 0, 0, 4'b0, 4'b0, 0); step();
    exp_st("jro_lo",  0, 0, 0, 0, 0, 4'b0, 4'b0, 0);
    run = 1'b0;
    step();
    wr(0, ins(5, 0, 0, 9));
    run = 1'b1;
    exp_st("jmp_c0",  0, 0, 0, 0, 0, 4'b0, 4'b0, 0); step();
    exp_st("jmp_clp", 3, 0, 0, 0, 0, 4'b0, 4'b0, 0);
    run = 1'b0;
    step();

    // 4: MOV UP,ACC blocked for 3 cycles
    pulse_rst();
    wr(0, ins(1, 3, 1, 0));
    wr(1, ins(0, 0, 0, 0));
    prog_len = 4'd2;
    in_data[0] = 11'd42;
    run = 1'b1;
    exp_st("rd_wait0", 0, 0, 0, 0, 1, 4'b0001, 4'b0, 0); step();
    exp_st("rd_wait1", 0, 0, 0, 0, 1, 4'b0001, 4'b0, 0); step();
    exp_st("rd_wait2", 0, 0, 0, 0, 1, 4'b0001, 4'b0, 0); step();
    in_valid[0] = 1'b1;
    exp_st("rd_hs",    0, 0, 0, 0, 0, 4'b0001, 4'b0, 0); step();
    in_valid[0] = 1'b0;
    exp_st("rd_done",  1, 42, 0, 0, 0, 4'b0000, 4'b0, 0);
    run = 1'b0;
    step();

    // 5: MOV -17,RIGHT with a slow neighbour
    pulse_rst();
    wr(0, ins(1, 0, 6, -17));
    wr(1, ins(0, 0, 0, 0));
    prog_len = 4'd2;
    run = 1'b1;
    q_out.push_back('{port: 3, data: -17});
    exp_st("wr_issue", 0, 0, 0, 0, 0, 4'b0, 4'b0000, 0);   step();
    exp_st("wr_wait0", 0, 0, 0, 0, 1, 4'b0, 4'b1000, -17); step();
    exp_st("wr_wait1", 0, 0, 0, 0, 1, 4'b0, 4'b1000, -17); step();
    out_ready[3] = 1'b1;
    exp_st("wr_hs",    0, 0, 0, 0, 1, 4'b0, 4'b1000, -17); step();
    out_ready[3] = 1'b0;
    exp_st("wr_done",  1, 0, 0, 0, 0, 4'b0, 4'b0000, -17);
    run = 1'b0;
    step();

    // 6a: HCF freezes the node and blocks input
    pulse_rst();
    wr(0, ins(2, 0, 0, 7));
    wr(1, ins(13, 0, 0, 0));
    wr(2, ins(1, 3, 1, 0));
    prog_len = 4'd3;
    in_valid[0] = 1'b1;
    run = 1'b1;
    exp_st("hcf_c0",  0, 0, 0, 0, 0, 4'b0, 4'b0, 0); step();
    exp_st("hcf_c1",  1, 7, 0, 0, 0, 4'b0, 4'b0, 0); step();
    exp_st("halt_c0", 1, 7, 0, 1, 0, 4'b0, 4'b0, 0); step();
    exp_st("halt_c1", 1, 7, 0, 1, 0, 4'b0, 4'b0, 0);
    run = 1'b0;
    in_valid[0] = 1'b0;
    step();

    // 6b: asynchronous reset in the middle of a pending write
    pulse_rst();
    wr(0, ins(1, 0, 4, 5));
    prog_len = 4'd1;
    run = 1'b1;
    exp_st("ar_issue", 0, 0, 0, 0, 0, 4'b0, 4'b0000, 0); step();
    exp_st("ar_wait",  0, 0, 0, 0, 1, 4'b0, 4'b0010, 0); step();
    rst = 1'b1;
    #1;
    exp_st("ar_reset", 0, 0, 0, 0, 0, 4'b0, 4'b0000, 0);
    step();
    run = 1'b0;
    rst = 1'b0;
    step();
    step();

    n_cmp++;
    if (q_snap.size() != 0) begin
      n_fail++;
      $display("FAIL snap_drain: got %0d pending; want 0", q_snap.size());
    end
    n_cmp++;
    if (q_out.size() != 0) begin
      n_fail++;
      $display("FAIL out_drain: got %0d pending writes; want 0", q_out.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout; want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
